// File: rtl/request_ingress_pkg.sv
// Shared definitions for the DRAM batch scheduler ingress: default field
// widths, the address field origin and the ingress FSM state encodings.
package request_ingress_pkg;

  // Default field widths of the flat physical address {row, bank, bg, col}
  localparam int DEF_BG_W   = 2;
  localparam int DEF_BANK_W = 2;
  localparam int DEF_ROW_W  = 16;
  localparam int DEF_COL_W  = 10;

  // Column occupies the least significant bits; the other fields stack above it
  localparam int ADDR_COL_LSB = 0;

  // Ingress batch-formation states
  typedef enum logic [1:0] {
    ING_IDLE   = 2'd0,
    ING_FILL   = 2'd1,
    ING_CLOSED = 2'd2,
    ING_CLEAR  = 2'd3
  } ing_state_t;

endpackage

// File: rtl/request_ingress_skid_fifo.sv
// Two-entry skid FIFO holding decoded request fields. The ready flag is a
// register derived from the next occupancy, so the upstream side never sees
// a combinational path from the pop side.
module ingress_skid_fifo #(
  parameter int WIDTH = 30
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_valid,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             empty,
  output logic             ready
);

  logic [WIDTH-1:0] mem_reg [2];
  logic             wr_ptr_reg;
  logic             rd_ptr_reg;
  logic [1:0]       count_reg;
  logic [1:0]       count_next;
  logic             ready_reg;
  logic             push_en;
  logic             pop_en;

  assign push_en   = push_valid && ready_reg;
  assign pop_en    = pop && (count_reg != 2'd0);
  assign head_data = mem_reg[rd_ptr_reg];
  assign empty     = (count_reg == 2'd0);
  assign ready     = ready_reg;

  // Occupancy after this cycle's push/pop
  always_comb begin
    count_next = count_reg;
    if (push_en && !pop_en) begin
      count_next = count_reg + 2'd1;
    end else if (!push_en && pop_en) begin
      count_next = count_reg - 2'd1;
    end
  end

  // Storage, pointers, occupancy and registered ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_reg[0] <= '0;
      mem_reg[1] <= '0;
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
      ready_reg  <= 1'b0;
    end else begin
      if (push_en) begin
        mem_reg[wr_ptr_reg] <= push_data;
        wr_ptr_reg          <= ~wr_ptr_reg;
      end
      if (pop_en) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
      count_reg <= count_next;
      ready_reg <= (count_next != 2'd2);
    end
  end

endmodule

// File: rtl/request_ingress.sv
// Front end of the DRAM batch scheduler. Decodes flat addresses into
// bank group / bank / row / column, buffers them in a 2-entry skid FIFO and
// forms batches: a batch closes on full count, timeout or flush, stays
// closed (batch_start) until the scheduler reports done, then batch_clear
// pulses for one cycle before the next batch may start.
module request_ingress
  import request_ingress_pkg::*;
#(
  parameter int ADDR_WIDTH     = 30,
  parameter int BG_W           = DEF_BG_W,
  parameter int BANK_W         = DEF_BANK_W,
  parameter int ROW_W          = DEF_ROW_W,
  parameter int COL_W          = DEF_COL_W,
  parameter int BATCH_MAX      = 16,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  output logic                  in_ready,
  input  logic                  flush,
  output logic                  out_valid,
  output logic [BG_W-1:0]       out_bank_group,
  output logic [BANK_W-1:0]     out_bank,
  output logic [ROW_W-1:0]      out_row,
  output logic [COL_W-1:0]      out_column,
  input  logic                  out_ready,
  output logic                  batch_start,
  input  logic                  batch_done,
  output logic                  batch_clear,
  output logic [CNT_W-1:0]      batch_count
);

  localparam int ADDR_BG_LSB   = ADDR_COL_LSB + COL_W;
  localparam int ADDR_BANK_LSB = ADDR_BG_LSB + BG_W;
  localparam int ADDR_ROW_LSB  = ADDR_BANK_LSB + BANK_W;
  localparam int FIELD_W       = ROW_W + BANK_W + BG_W + COL_W;
  localparam int TMR_W         = $clog2(TIMEOUT_CYCLES) + 1;

  localparam logic [CNT_W-1:0] BATCH_MAX_C  = CNT_W'(BATCH_MAX);
  localparam logic [CNT_W-1:0] BATCH_LAST_C = CNT_W'(BATCH_MAX - 1);
  localparam logic [TMR_W-1:0] TMO_LAST_C   = TMR_W'(TIMEOUT_CYCLES - 1);

  ing_state_t        state_reg;
  ing_state_t        state_next;
  logic [CNT_W-1:0]  batch_count_reg;
  logic [TMR_W-1:0]  timer_reg;

  logic [COL_W-1:0]  dec_col;
  logic [BG_W-1:0]   dec_bg;
  logic [BANK_W-1:0] dec_bank;
  logic [ROW_W-1:0]  dec_row;
  logic [FIELD_W-1:0] push_data;
  logic [FIELD_W-1:0] head_data;
  logic              fifo_empty;
  logic              handshake;

  // Address decode happens on the way into the FIFO; only fields are stored
  assign dec_col   = in_addr[ADDR_COL_LSB +: COL_W];
  assign dec_bg    = in_addr[ADDR_BG_LSB +: BG_W];
  assign dec_bank  = in_addr[ADDR_BANK_LSB +: BANK_W];
  assign dec_row   = in_addr[ADDR_ROW_LSB +: ROW_W];
  assign push_data = {dec_row, dec_bank, dec_bg, dec_col};

  assign {out_row, out_bank, out_bank_group, out_column} = head_data;
  assign handshake   = out_valid && out_ready;
  assign batch_count = batch_count_reg;

  ingress_skid_fifo #(
    .WIDTH (FIELD_W)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_valid (in_valid),
    .push_data  (push_data),
    .pop        (handshake),
    .head_data  (head_data),
    .empty      (fifo_empty),
    .ready      (in_ready)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ING_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state: close on count, timeout or flush; wait for done; clear once
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ING_IDLE: begin
        if (handshake) begin
          state_next = (BATCH_MAX_C == CNT_W'(1)) ? ING_CLOSED : ING_FILL;
        end
      end
      ING_FILL: begin
        if ((handshake && (batch_count_reg == BATCH_LAST_C)) ||
            (timer_reg == TMO_LAST_C) || flush) begin
          state_next = ING_CLOSED;
        end
      end
      ING_CLOSED: begin
        if (batch_done) begin
          state_next = ING_CLEAR;
        end
      end
      ING_CLEAR: begin
        state_next = ING_IDLE;
      end
      default: begin
        state_next = ING_IDLE;
      end
    endcase
  end

  // Outputs: forward only while a batch is open and not yet full
  always_comb begin
    out_valid   = !fifo_empty &&
                  ((state_reg == ING_IDLE) || (state_reg == ING_FILL)) &&
                  (batch_count_reg != BATCH_MAX_C);
    batch_start = (state_reg == ING_CLOSED);
    batch_clear = (state_reg == ING_CLEAR);
  end

  // Batch counter and timeout timer; timer reads 1 in the cycle after the
  // first handshake so the close lands exactly TIMEOUT_CYCLES after it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      batch_count_reg <= '0;
      timer_reg       <= '0;
    end else begin
      case (state_reg)
        ING_IDLE: begin
          if (handshake) begin
            batch_count_reg <= CNT_W'(1);
            timer_reg       <= TMR_W'(1);
          end else begin
            batch_count_reg <= '0;
            timer_reg       <= '0;
          end
        end
        ING_FILL: begin
          timer_reg <= timer_reg + TMR_W'(1);
          if (handshake) begin
            batch_count_reg <= batch_count_reg + CNT_W'(1);
          end
        end
        ING_CLOSED: begin
          batch_count_reg <= batch_count_reg;
          timer_reg       <= timer_reg;
        end
        default: begin
          batch_count_reg <= '0;
          timer_reg       <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_request_ingress.sv
// Directed bench for request_ingress: a decode vector table plus hand-written
// sequences for batch close, timeout, done/clear, backpressure, flush and reset.
module tb_request_ingress;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [29:0] in_addr;
  logic        in_ready;
  logic        flush;
  logic        out_valid;
  logic [1:0]  out_bank_group;
  logic [1:0]  out_bank;
  logic [15:0] out_row;
  logic [9:0]  out_column;
  logic        out_ready;
  logic        batch_start;
  logic        batch_done;
  logic        batch_clear;
  logic [4:0]  batch_count;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [29:0] addr;
    logic [15:0] row;
    logic [1:0]  bank;
    logic [1:0]  bg;
    logic [9:0]  col;
  } vec_t;

  vec_t vecs [5];

  request_ingress dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_addr        (in_addr),
    .in_ready       (in_ready),
    .flush          (flush),
    .out_valid      (out_valid),
    .out_bank_group (out_bank_group),
    .out_bank       (out_bank),
    .out_row        (out_row),
    .out_column     (out_column),
    .out_ready      (out_ready),
    .batch_start    (batch_start),
    .batch_done     (batch_done),
    .batch_clear    (batch_clear),
    .batch_count    (batch_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end else begin
      $display("ok   %s value=%0h", name, act);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic done_and_clear(input string tag);
    batch_done = 1'b1;
    tick();
    batch_done = 1'b0;
    chk({tag, "_clear_pulse"}, 32'(batch_clear), 32'd1);
    tick();
    chk({tag, "_clear_gone"}, 32'(batch_clear), 32'd0);
    chk({tag, "_start_low"}, 32'(batch_start), 32'd0);
    chk({tag, "_count_zero"}, 32'(batch_count), 32'd0);
  endtask

  initial begin
    int pushes;
    int pops;
    int n;
    logic p;
    logic h;
    logic [15:0] r;

    vecs[0] = '{addr: 30'h048D3555, row: 16'h1234, bank: 2'd3, bg: 2'd1, col: 10'h155};
    vecs[1] = '{addr: 30'h3FFFFFFF, row: 16'hFFFF, bank: 2'd3, bg: 2'd3, col: 10'h3FF};
    vecs[2] = '{addr: 30'h00000800, row: 16'h0000, bank: 2'd0, bg: 2'd2, col: 10'h000};
    vecs[3] = '{addr: 30'h200062AA, row: 16'h8001, bank: 2'd2, bg: 2'd0, col: 10'h2AA};
    vecs[4] = '{addr: 30'h00005000, row: 16'h0001, bank: 2'd1, bg: 2'd0, col: 10'h000};

    rst_n = 1'b0; in_valid = 1'b0; in_addr = '0; flush = 1'b0;
    out_ready = 1'b0; batch_done = 1'b0;

    // Reset values
    tick(); tick();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_batch_start", 32'(batch_start), 32'd0);
    chk("rst_batch_clear", 32'(batch_clear), 32'd0);
    chk("rst_batch_count", 32'(batch_count), 32'd0);
    chk("rst_out_row", 32'(out_row), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("rel_in_ready", 32'(in_ready), 32'd1);

    // Decode table: one push, check fields under backpressure, then hand over
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_addr = vecs[i].addr; out_ready = 1'b0;
      tick();
      in_valid = 1'b0;
      chk("dec_out_valid", 32'(out_valid), 32'd1);
      chk("dec_row", 32'(out_row), 32'(vecs[i].row));
      chk("dec_bank", 32'(out_bank), 32'(vecs[i].bank));
      chk("dec_bg", 32'(out_bank_group), 32'(vecs[i].bg));
      chk("dec_col", 32'(out_column), 32'(vecs[i].col));
      chk("dec_count_before", 32'(batch_count), 32'(i));
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("dec_count_after", 32'(batch_count), 32'(i + 1));
      chk("dec_no_start", 32'(batch_start), 32'd0);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush5_start", 32'(batch_start), 32'd1);
    chk("flush5_count", 32'(batch_count), 32'd5);
    done_and_clear("c1");

    // Full close: back-to-back traffic until the FIFO fills behind a closed batch
    pushes = 0; pops = 0;
    r = 16'h0100;
    in_valid = 1'b1; in_addr = {r, 14'h0}; out_ready = 1'b1;
    for (int c = 0; c < 60; c++) begin
      p = in_valid && in_ready;
      h = out_valid && out_ready;
      if (h) begin
        chk("full_order", 32'(out_row), 32'(16'h0100 + 16'(pops)));
        pops++;
      end
      tick();
      if (p) begin
        pushes++;
        r = 16'h0100 + 16'(pushes);
        in_addr = {r, 14'h0};
      end
      if (h && pops == 16) begin
        chk("full_start", 32'(batch_start), 32'd1);
        chk("full_count", 32'(batch_count), 32'd16);
        chk("full_out_valid", 32'(out_valid), 32'd0);
      end
      if (!in_ready) break;
    end
    in_valid = 1'b0;
    chk("full_pops", 32'(pops), 32'd16);
    chk("full_pushes", 32'(pushes), 32'd18);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_still_closed", 32'(batch_start), 32'd1);

    // Done/clear then buffered requests drain in order; flush at count 2
    done_and_clear("c2");
    chk("drain0_valid", 32'(out_valid), 32'd1);
    chk("drain0_row", 32'(out_row), 32'h0110);
    tick();
    chk("drain1_row", 32'(out_row), 32'h0111);
    chk("drain1_count", 32'(batch_count), 32'd1);
    tick();
    out_ready = 1'b0;
    chk("drain_count2", 32'(batch_count), 32'd2);
    chk("drain_empty", 32'(out_valid), 32'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush2_start", 32'(batch_start), 32'd1);
    chk("flush2_count", 32'(batch_count), 32'd2);
    done_and_clear("c3");

    // Flush and batch_done in IDLE are ignored
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    chk("idle_flush_ignored", 32'(batch_start), 32'd0);
    batch_done = 1'b1;
    tick();
    batch_done = 1'b0;
    chk("idle_done_ignored", 32'(batch_clear), 32'd0);

    // Backpressure: head stable, upstream stalled with two queued
    in_valid = 1'b1; in_addr = {16'hA0A0, 14'h0};
    tick();
    in_addr = {16'hB0B0, 14'h0};
    tick();
    chk("bp_full_ready", 32'(in_ready), 32'd0);
    in_addr = {16'hC0C0, 14'h0};
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("bp_row_stable", 32'(out_row), 32'hA0A0);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;

    // Timeout: three requests, then idle until the forced close
    out_ready = 1'b1;
    tick();
    n = 1;
    in_valid = 1'b1; in_addr = {16'hC0C0, 14'h0};
    tick(); n++;
    in_valid = 1'b0;
    chk("tmo_second_row", 32'(out_row), 32'hC0C0);
    tick(); n++;
    out_ready = 1'b0;
    chk("tmo_count3", 32'(batch_count), 32'd3);
    while (!batch_start && n < 200) begin
      tick(); n++;
    end
    chk("tmo_cycles", 32'(n), 32'd64);
    chk("tmo_count", 32'(batch_count), 32'd3);
    done_and_clear("c4");

    // Reset while CLOSED with requests queued
    in_valid = 1'b1; in_addr = {16'hD0D0, 14'h0}; out_ready = 1'b1;
    tick();
    in_addr = {16'hE0E0, 14'h0};
    tick();
    flush = 1'b1; in_addr = {16'hF0F0, 14'h0};
    tick();
    flush = 1'b0; in_addr = {16'h0F0F, 14'h0};
    tick();
    in_valid = 1'b0;
    chk("rc_closed", 32'(batch_start), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rc_start", 32'(batch_start), 32'd0);
    chk("rc_out_valid", 32'(out_valid), 32'd0);
    chk("rc_count", 32'(batch_count), 32'd0);
    chk("rc_in_ready", 32'(in_ready), 32'd0);
    chk("rc_row", 32'(out_row), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("rc_rel_ready", 32'(in_ready), 32'd1);
    chk("rc_rel_empty", 32'(out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
